// File: rtl/ram_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the work-RAM arbiter and the RAM itself.
// slave = arbiter side; master = requesters plus RAM (testbench side).
interface ram_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_rdy;
    logic [DW-1:0] c_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_sel;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [DW-1:0] m_dout;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_dout,
        output c_rdy, c_rdata, d_gnt, d_rvalid, d_rdata, m_sel, m_we, m_addr, m_din
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, m_dout,
        input  c_rdy, c_rdata, d_gnt, d_rvalid, d_rdata, m_sel, m_we, m_addr, m_din
    );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port work-RAM arbiter: CPU has priority, DMA is guaranteed one slot after
// CPU_BURST consecutive CPU grants; read data is steered back to the access owner.
module ram_arbiter #(
    parameter int AW        = 15,
    parameter int DW        = 8,
    parameter int CPU_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_D} owner_e;

    localparam logic [3:0] BURST_MAX = 4'(CPU_BURST);

    logic [3:0] burst_cnt_q, burst_cnt_d;
    owner_e     rd_owner_q, rd_owner_d;
    logic       grant_c, grant_d;
    logic       burst_limit;

    assign burst_limit = (burst_cnt_q >= BURST_MAX);

    // Grants are suppressed while reset is held so nothing reaches the RAM mid-reset.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (bus.c_req && (!bus.d_req || !burst_limit))
                grant_c = 1'b1;
            else if (bus.d_req)
                grant_d = 1'b1;
        end
    end

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (!bus.d_req || grant_d)
            burst_cnt_d = '0;
        else if (grant_c && !burst_limit)
            burst_cnt_d = burst_cnt_q + 4'd1;
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (grant_c && !bus.c_we)
            rd_owner_d = OWN_C;
        else if (grant_d && !bus.d_we)
            rd_owner_d = OWN_D;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_q <= '0;
            rd_owner_q  <= OWN_NONE;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            rd_owner_q  <= rd_owner_d;
        end
    end

    always_comb begin
        bus.m_sel    = grant_c | grant_d;
        bus.m_we     = 1'b0;
        bus.m_addr   = '0;
        bus.m_din    = '0;
        if (grant_c) begin
            bus.m_we   = bus.c_we;
            bus.m_addr = bus.c_addr;
            bus.m_din  = bus.c_wdata;
        end else if (grant_d) begin
            bus.m_we   = bus.d_we;
            bus.m_addr = bus.d_addr;
            bus.m_din  = bus.d_wdata;
        end
        bus.c_rdy    = ~bus.c_req | grant_c;
        bus.d_gnt    = grant_d;
        // Read data is shared; only the DMA side needs a qualifier.
        bus.d_rvalid = (rd_owner_q == OWN_D);
        bus.c_rdata  = bus.m_dout;
        bus.d_rdata  = bus.m_dout;
    end
endmodule
